integer_dispatch: RTL and testbench
===================================

// Module: integer_dispatch
// PURPOSE
//  Producer side of the dispatch->IIQ ready/valid interface. Accepts one decoded integer op per cycle,
//  allocates a ROB tag and renames sources through an arch-reg busy/tag table. Reads ready operands
//  from the ARF, or captures them from the writeback bus. Emits a registered iiq_entry_t to integer_issue.
// PARAMETERS
//  N_ARCH_REGS    32  architectural integer registers (x0 hardwired zero)
//  ROB_TAG_WIDTH  4   from `ROB_TAG_WIDTH; ROB depth = 2**ROB_TAG_WIDTH
//  XLEN           32  operand/data width
// PORTS
//  clk            in   1              clock
//  rst_aL         in   1              async active-low reset
//  decode_valid   in   1              decoded op available
//  decode_ready   out  1              op accepted this cycle when decode_valid && decode_ready
//  decode_op      in   `IIQ_OP_W      ALU op encoding
//  decode_rs1/rs2 in   5 each         source arch regs
//  decode_rd      in   5              dest arch reg
//  decode_rd_wr   in   1              op writes rd
//  decode_imm     in   XLEN           immediate
//  rob_alloc_ready in  1              ROB not full
//  rob_tail_tag   in   ROB_TAG_WIDTH  tag granted on allocation
//  rob_alloc_valid out 1              = accept (combinational); ROB advances tail
//  arf_rs1_addr/arf_rs2_addr out 5    ARF read addrs (= decode_rs1/rs2)
//  arf_rs1_data/arf_rs2_data in XLEN  combinational ARF read data
//  wb_valid       in   1              writeback broadcast
//  wb_tag         in   ROB_TAG_WIDTH  producer tag
//  wb_data        in   XLEN           result
//  retire_valid   in   1              ROB commit
//  retire_rd      in   5              committed dest reg
//  retire_tag     in   ROB_TAG_WIDTH  committed tag
//  flush          in   1              pipeline flush
//  dispatch_valid out  1              to IIQ enq_valid
//  dispatch_ready in   1              from IIQ enq_ready
//  dispatch_data  out  iiq_entry_t    {op,rob_tag,rd,rd_wr,src1_rdy,src1_tag,src1_val,src2_*,imm}
// BEHAVIOUR
//  Reset: dispatch_valid=0, dispatch_data=0, all RAT entries not busy. decode_ready is combinational.
//  decode_ready = rob_alloc_ready && !flush && (!dispatch_valid || dispatch_ready); accept = valid&&ready.
//  Latency: accept in cycle N -> dispatch_valid=1 with the entry in cycle N+1. Throughput 1/cycle.
//  Source resolve at accept (RAT read precedes same-op rd update):
//    src==x0 -> rdy=1, val=0. RAT not busy -> rdy=1, val=ARF data.
//    Busy and wb_valid && wb_tag==RAT tag -> rdy=1, val=wb_data (same-cycle bypass).
//    Otherwise rdy=0, tag=RAT tag.
//  RAT update at accept: if rd_wr && rd!=0 -> RAT[rd]={busy=1, tag=rob_tail_tag}.
//  Retire: clears RAT[retire_rd].busy only if its tag==retire_tag.
//    Same-cycle accept to the same rd wins (entry stays busy with the new tag).
//  Held-entry snoop: while dispatch_valid, a src with rdy=0 and tag==wb_tag (wb_valid) becomes rdy=1,
//    val=wb_data next cycle. Otherwise dispatch_data stays stable until dispatch_valid && dispatch_ready.
//  Output register: handshake without accept -> dispatch_valid=0. Handshake with accept -> new entry loads.
//  Flush (sync, highest priority): next cycle dispatch_valid=0 and all RAT busy=0. No accept and no
//    rob_alloc_valid in the flush cycle. Async reset mid-operation drops any held entry.
// STRUCTURE
//  Package/global_defs.svh: iiq_entry_t, ROB_TAG_WIDTH, IIQ_OP_W, op encodings, XLEN.
//  Sub-module rename_table: N_ARCH_REGS x {busy,tag}. 2 combinational read ports, 1 alloc write port,
//    1 retire-clear port, flush-clear. Write takes priority over clear.
//  Top level: handshake logic, operand select/bypass, output register with wb snoop.
// TESTING
//  1 Reset; ARF x2=5, x3=7; ADD x1,x2,x3, tail=0 -> next cycle dispatch_valid=1,
//    src1 rdy/val=1/5, src2 1/7, rob_tag=0.
//  2 A: rd=x5 gets tag 0. B: rs1=x5 -> src1_rdy=0, tag=0. Hold with dispatch_ready=0; wb tag0 data 42
//    -> src1_rdy=1, val=42. Variant: wb in B's accept cycle -> rdy=1 at output.
//  3 dispatch_ready=0 for 3 cycles with valid output -> decode_ready=0, rob_alloc_valid=0,
//    dispatch_data stable.
//  4 RAT x5 = tag 0. Same cycle: retire x5/tag0 and accept rd=x5 with tail=3 -> RAT x5 busy, tag 3.
//    Retire x5/tag2 -> no change.
//  5 Flush with dispatch_valid=1 and x5 busy -> next cycle dispatch_valid=0; later rs1=x5 reads ARF, rdy=1.
//  6 rd=x0 write, then rs1=x0 -> rdy=1, val=0. rob_alloc_ready=0 -> decode_ready=0, no accept.

Source files
------------

// File: rtl/integer_dispatch_pkg.sv
// Shared types and constants for the integer dispatch stage feeding the integer issue queue.
package integer_dispatch_pkg;

    localparam int unsigned XLEN          = 32;
    localparam int unsigned ROB_TAG_WIDTH = 4;
    localparam int unsigned N_ARCH_REGS   = 32;
    localparam int unsigned AREG_W        = $clog2(N_ARCH_REGS);
    localparam int unsigned IIQ_OP_W      = 4;

    typedef enum logic [IIQ_OP_W-1:0] {
        OP_ADD  = 4'h0,
        OP_SUB  = 4'h1,
        OP_AND  = 4'h2,
        OP_OR   = 4'h3,
        OP_XOR  = 4'h4,
        OP_SLL  = 4'h5,
        OP_SRL  = 4'h6,
        OP_SRA  = 4'h7,
        OP_SLT  = 4'h8,
        OP_SLTU = 4'h9
    } iiq_op_e;

    typedef struct packed {
        logic                     rdy;
        logic [ROB_TAG_WIDTH-1:0] tag;
        logic [XLEN-1:0]          val;
    } src_opnd_t;

    typedef struct packed {
        logic [IIQ_OP_W-1:0]      op;
        logic [ROB_TAG_WIDTH-1:0] rob_tag;
        logic [AREG_W-1:0]        rd;
        logic                     rd_wr;
        logic                     src1_rdy;
        logic [ROB_TAG_WIDTH-1:0] src1_tag;
        logic [XLEN-1:0]          src1_val;
        logic                     src2_rdy;
        logic [ROB_TAG_WIDTH-1:0] src2_tag;
        logic [XLEN-1:0]          src2_val;
        logic [XLEN-1:0]          imm;
    } iiq_entry_t;

    // A source is ready unless it names a busy register whose producer is not on the bus this cycle.
    function automatic src_opnd_t resolve_src(
        input logic [AREG_W-1:0]        areg,
        input logic                     busy,
        input logic [ROB_TAG_WIDTH-1:0] rat_tag,
        input logic [XLEN-1:0]          arf_data,
        input logic                     wb_v,
        input logic [ROB_TAG_WIDTH-1:0] wb_t,
        input logic [XLEN-1:0]          wb_d
    );
        src_opnd_t s;
        s.rdy = 1'b1;
        s.tag = '0;
        s.val = '0;
        if (areg != '0) begin
            if (!busy) begin
                s.val = arf_data;
            end else if (wb_v && (wb_t == rat_tag)) begin
                s.val = wb_d;
            end else begin
                s.rdy = 1'b0;
                s.tag = rat_tag;
            end
        end
        return s;
    endfunction

endpackage

// File: rtl/integer_dispatch_rename_table.sv
// Architectural-register busy/tag table: two combinational read ports, one allocate port,
// one tag-qualified retire-clear port and a global flush clear.
module integer_dispatch_rename_table
    import integer_dispatch_pkg::*;
(
    input  logic                     clk,
    input  logic                     rst_aL,
    input  logic [AREG_W-1:0]        rs1_addr_i,
    output logic                     rs1_busy_c_o,
    output logic [ROB_TAG_WIDTH-1:0] rs1_tag_c_o,
    input  logic [AREG_W-1:0]        rs2_addr_i,
    output logic                     rs2_busy_c_o,
    output logic [ROB_TAG_WIDTH-1:0] rs2_tag_c_o,
    input  logic                     alloc_en_i,
    input  logic [AREG_W-1:0]        alloc_addr_i,
    input  logic [ROB_TAG_WIDTH-1:0] alloc_tag_i,
    input  logic                     retire_en_i,
    input  logic [AREG_W-1:0]        retire_addr_i,
    input  logic [ROB_TAG_WIDTH-1:0] retire_tag_i,
    input  logic                     flush_i
);

    logic [N_ARCH_REGS-1:0]   busy_q, busy_d;
    logic [ROB_TAG_WIDTH-1:0] tag_q [N_ARCH_REGS];
    logic [ROB_TAG_WIDTH-1:0] tag_d [N_ARCH_REGS];

    assign rs1_busy_c_o = busy_q[rs1_addr_i];
    assign rs1_tag_c_o  = tag_q[rs1_addr_i];
    assign rs2_busy_c_o = busy_q[rs2_addr_i];
    assign rs2_tag_c_o  = tag_q[rs2_addr_i];

    // Allocation is applied after the retire clear so a same-cycle rename of the register wins.
    always_comb begin
        busy_d = busy_q;
        tag_d  = tag_q;
        if (flush_i) begin
            busy_d = '0;
        end else begin
            if (retire_en_i && (tag_q[retire_addr_i] == retire_tag_i)) begin
                busy_d[retire_addr_i] = 1'b0;
            end
            if (alloc_en_i) begin
                busy_d[alloc_addr_i] = 1'b1;
                tag_d[alloc_addr_i]  = alloc_tag_i;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_aL) begin
        if (!rst_aL) begin
            busy_q <= '0;
            for (int unsigned i = 0; i < N_ARCH_REGS; i++) begin
                tag_q[i] <= '0;
            end
        end else begin
            busy_q <= busy_d;
            tag_q  <= tag_d;
        end
    end

endmodule

// File: rtl/integer_dispatch.sv
// Integer dispatch: renames sources, allocates a ROB tag and hands a registered entry to the IIQ,
// snooping the writeback bus while the entry waits for the queue to accept it.
module integer_dispatch
    import integer_dispatch_pkg::*;
(
    input  logic                     clk,
    input  logic                     rst_aL,
    input  logic                     decode_valid,
    output logic                     decode_ready,
    input  logic [IIQ_OP_W-1:0]      decode_op,
    input  logic [AREG_W-1:0]        decode_rs1,
    input  logic [AREG_W-1:0]        decode_rs2,
    input  logic [AREG_W-1:0]        decode_rd,
    input  logic                     decode_rd_wr,
    input  logic [XLEN-1:0]          decode_imm,
    input  logic                     rob_alloc_ready,
    input  logic [ROB_TAG_WIDTH-1:0] rob_tail_tag,
    output logic                     rob_alloc_valid,
    output logic [AREG_W-1:0]        arf_rs1_addr,
    output logic [AREG_W-1:0]        arf_rs2_addr,
    input  logic [XLEN-1:0]          arf_rs1_data,
    input  logic [XLEN-1:0]          arf_rs2_data,
    input  logic                     wb_valid,
    input  logic [ROB_TAG_WIDTH-1:0] wb_tag,
    input  logic [XLEN-1:0]          wb_data,
    input  logic                     retire_valid,
    input  logic [AREG_W-1:0]        retire_rd,
    input  logic [ROB_TAG_WIDTH-1:0] retire_tag,
    input  logic                     flush,
    output logic                     dispatch_valid,
    input  logic                     dispatch_ready,
    output iiq_entry_t               dispatch_data
);

    logic                     dispatch_valid_q, dispatch_valid_d;
    iiq_entry_t               entry_q, entry_d;
    iiq_entry_t               new_entry;
    logic                     accept;
    logic                     rs1_busy, rs2_busy;
    logic [ROB_TAG_WIDTH-1:0] rs1_tag, rs2_tag;
    src_opnd_t                src1, src2;

    assign decode_ready    = rob_alloc_ready && !flush && (!dispatch_valid_q || dispatch_ready);
    assign accept          = decode_valid && decode_ready;
    assign rob_alloc_valid = accept;
    assign arf_rs1_addr    = decode_rs1;
    assign arf_rs2_addr    = decode_rs2;
    assign dispatch_valid  = dispatch_valid_q;
    assign dispatch_data   = entry_q;

    integer_dispatch_rename_table u_rat (
        .clk           (clk),
        .rst_aL        (rst_aL),
        .rs1_addr_i    (decode_rs1),
        .rs1_busy_c_o  (rs1_busy),
        .rs1_tag_c_o   (rs1_tag),
        .rs2_addr_i    (decode_rs2),
        .rs2_busy_c_o  (rs2_busy),
        .rs2_tag_c_o   (rs2_tag),
        .alloc_en_i    (accept && decode_rd_wr && (decode_rd != '0)),
        .alloc_addr_i  (decode_rd),
        .alloc_tag_i   (rob_tail_tag),
        .retire_en_i   (retire_valid),
        .retire_addr_i (retire_rd),
        .retire_tag_i  (retire_tag),
        .flush_i       (flush)
    );

    always_comb begin
        src1 = resolve_src(decode_rs1, rs1_busy, rs1_tag, arf_rs1_data, wb_valid, wb_tag, wb_data);
        src2 = resolve_src(decode_rs2, rs2_busy, rs2_tag, arf_rs2_data, wb_valid, wb_tag, wb_data);
        new_entry          = '0;
        new_entry.op       = decode_op;
        new_entry.rob_tag  = rob_tail_tag;
        new_entry.rd       = decode_rd;
        new_entry.rd_wr    = decode_rd_wr;
        new_entry.src1_rdy = src1.rdy;
        new_entry.src1_tag = src1.tag;
        new_entry.src1_val = src1.val;
        new_entry.src2_rdy = src2.rdy;
        new_entry.src2_tag = src2.tag;
        new_entry.src2_val = src2.val;
        new_entry.imm      = decode_imm;
    end

    // Output register: flush > load new entry > drain on handshake > hold and snoop writeback.
    always_comb begin
        dispatch_valid_d = dispatch_valid_q;
        entry_d          = entry_q;
        if (flush) begin
            dispatch_valid_d = 1'b0;
        end else if (accept) begin
            dispatch_valid_d = 1'b1;
            entry_d          = new_entry;
        end else if (dispatch_valid_q && dispatch_ready) begin
            dispatch_valid_d = 1'b0;
        end else if (dispatch_valid_q && wb_valid) begin
            if (!entry_q.src1_rdy && (entry_q.src1_tag == wb_tag)) begin
                entry_d.src1_rdy = 1'b1;
                entry_d.src1_val = wb_data;
            end
            if (!entry_q.src2_rdy && (entry_q.src2_tag == wb_tag)) begin
                entry_d.src2_rdy = 1'b1;
                entry_d.src2_val = wb_data;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_aL) begin
        if (!rst_aL) begin
            dispatch_valid_q <= 1'b0;
            entry_q          <= '0;
        end else begin
            dispatch_valid_q <= dispatch_valid_d;
            entry_q          <= entry_d;
        end
    end

endmodule

// File: tb/tb_integer_dispatch.sv
// Self-checking bench for integer_dispatch: scoreboard of expected IIQ entries plus scenario tasks.
module tb_integer_dispatch;
    import integer_dispatch_pkg::*;

    logic                     clk = 1'b0;
    logic                     rst_aL;
    logic                     decode_valid, decode_ready;
    logic [IIQ_OP_W-1:0]      decode_op;
    logic [AREG_W-1:0]        decode_rs1, decode_rs2, decode_rd;
    logic                     decode_rd_wr;
    logic [XLEN-1:0]          decode_imm;
    logic                     rob_alloc_ready, rob_alloc_valid;
    logic [ROB_TAG_WIDTH-1:0] rob_tail_tag;
    logic [AREG_W-1:0]        arf_rs1_addr, arf_rs2_addr;
    logic [XLEN-1:0]          arf_rs1_data, arf_rs2_data;
    logic                     wb_valid;
    logic [ROB_TAG_WIDTH-1:0] wb_tag;
    logic [XLEN-1:0]          wb_data;
    logic                     retire_valid;
    logic [AREG_W-1:0]        retire_rd;
    logic [ROB_TAG_WIDTH-1:0] retire_tag;
    logic                     flush;
    logic                     dispatch_valid, dispatch_ready;
    iiq_entry_t               dispatch_data;

    logic [XLEN-1:0]          arf [N_ARCH_REGS];
    logic                     m_busy [N_ARCH_REGS];
    logic [ROB_TAG_WIDTH-1:0] m_tag [N_ARCH_REGS];
    iiq_entry_t               sb [$];
    int                       errors = 0;
    int                       checks = 0;

    always #5 clk = ~clk;

    assign arf_rs1_data = arf[arf_rs1_addr];
    assign arf_rs2_data = arf[arf_rs2_addr];

    integer_dispatch dut (
        .clk(clk), .rst_aL(rst_aL),
        .decode_valid(decode_valid), .decode_ready(decode_ready), .decode_op(decode_op),
        .decode_rs1(decode_rs1), .decode_rs2(decode_rs2), .decode_rd(decode_rd),
        .decode_rd_wr(decode_rd_wr), .decode_imm(decode_imm),
        .rob_alloc_ready(rob_alloc_ready), .rob_tail_tag(rob_tail_tag), .rob_alloc_valid(rob_alloc_valid),
        .arf_rs1_addr(arf_rs1_addr), .arf_rs2_addr(arf_rs2_addr),
        .arf_rs1_data(arf_rs1_data), .arf_rs2_data(arf_rs2_data),
        .wb_valid(wb_valid), .wb_tag(wb_tag), .wb_data(wb_data),
        .retire_valid(retire_valid), .retire_rd(retire_rd), .retire_tag(retire_tag),
        .flush(flush),
        .dispatch_valid(dispatch_valid), .dispatch_ready(dispatch_ready), .dispatch_data(dispatch_data)
    );

    function automatic src_opnd_t model_src(input logic [AREG_W-1:0] r, input logic [XLEN-1:0] arf_val);
        src_opnd_t s;
        s = '{rdy: 1'b1, tag: '0, val: '0};
        if (r == 0) return s;
        if (!m_busy[r]) s.val = arf_val;
        else if (wb_valid && wb_tag == m_tag[r]) s.val = wb_data;
        else begin
            s.rdy = 1'b0;
            s.tag = m_tag[r];
        end
        return s;
    endfunction

    task automatic model_clear();
        sb.delete();
        foreach (m_busy[i]) m_busy[i] = 1'b0;
    endtask

    task automatic drive_op(input int rs1, input int rs2, input int rd, input bit rd_wr, input int tail);
        decode_valid = 1'b1;
        decode_op    = IIQ_OP_W'(tail % 10);
        decode_rs1   = AREG_W'(rs1);
        decode_rs2   = AREG_W'(rs2);
        decode_rd    = AREG_W'(rd);
        decode_rd_wr = rd_wr;
        decode_imm   = XLEN'(32'h100 + tail);
        rob_tail_tag = ROB_TAG_WIDTH'(tail);
    endtask

    // One clock: predict from the inputs, advance the model past the edge, compare at the next negedge.
    task automatic tick();
        bit         vld, hs, rdy, acc;
        iiq_entry_t e, head;
        src_opnd_t  s1, s2;
        vld = (sb.size() != 0);
        hs  = vld && dispatch_ready;
        rdy = rob_alloc_ready && !flush && (!vld || dispatch_ready);
        acc = decode_valid && rdy;
        s1  = model_src(decode_rs1, arf[decode_rs1]);
        s2  = model_src(decode_rs2, arf[decode_rs2]);
        e   = '{op: decode_op, rob_tag: rob_tail_tag, rd: decode_rd, rd_wr: decode_rd_wr,
                src1_rdy: s1.rdy, src1_tag: s1.tag, src1_val: s1.val,
                src2_rdy: s2.rdy, src2_tag: s2.tag, src2_val: s2.val, imm: decode_imm};
        head = vld ? sb[0] : '0;
        if (wb_valid && !head.src1_rdy && head.src1_tag == wb_tag) begin
            head.src1_rdy = 1'b1; head.src1_val = wb_data;
        end
        if (wb_valid && !head.src2_rdy && head.src2_tag == wb_tag) begin
            head.src2_rdy = 1'b1; head.src2_val = wb_data;
        end
        @(posedge clk);
        #1;
        if (flush) begin
            model_clear();
        end else begin
            if (hs) void'(sb.pop_front());
            if (acc) sb.push_back(e);
            else if (vld && !hs) sb[0] = head;
            if (retire_valid && m_tag[retire_rd] == retire_tag) m_busy[retire_rd] = 1'b0;
            if (acc && decode_rd_wr && decode_rd != 0) begin
                m_busy[decode_rd] = 1'b1;
                m_tag[decode_rd]  = rob_tail_tag;
            end
        end
        decode_valid = 1'b0; wb_valid = 1'b0; retire_valid = 1'b0; flush = 1'b0;
        @(negedge clk);
        checks++;
        if (dispatch_valid !== (sb.size() != 0)) begin
            errors++;
            $display("FAIL sb_valid: dispatch_valid=%0b expected=%0b t=%0t", dispatch_valid, sb.size() != 0, $time);
        end
        if (sb.size() != 0) begin
            checks++;
            if (dispatch_data !== sb[0]) begin
                errors++;
                $display("FAIL sb_entry: got=%h expected=%h t=%0t", dispatch_data, sb[0], $time);
            end
        end
    endtask

    task automatic test_reset();
        rst_aL = 1'b0;
        repeat (2) @(negedge clk);
        checks++;
        if (dispatch_valid !== 1'b0 || dispatch_data !== '0) begin
            errors++;
            $display("FAIL reset_out: valid=%0b data=%h expected 0/0", dispatch_valid, dispatch_data);
        end
        rst_aL = 1'b1;
        model_clear();
        #1;
        checks++;
        if (decode_ready !== 1'b1) begin
            errors++;
            $display("FAIL reset_ready: decode_ready=%0b expected=1", decode_ready);
        end
    endtask

    task automatic test_basic();
        dispatch_ready = 1'b0;
        drive_op(2, 3, 1, 1'b1, 0);
        #1;
        checks++;
        if (rob_alloc_valid !== 1'b1) begin
            errors++;
            $display("FAIL basic_alloc: rob_alloc_valid=%0b expected=1", rob_alloc_valid);
        end
        tick();
        checks++;
        if (dispatch_valid !== 1'b1 || dispatch_data.src1_rdy !== 1'b1 || dispatch_data.src1_val !== 32'd5 ||
            dispatch_data.src2_rdy !== 1'b1 || dispatch_data.src2_val !== 32'd7 || dispatch_data.rob_tag !== 4'd0) begin
            errors++;
            $display("FAIL basic_add: v=%0b s1=%0b/%0d s2=%0b/%0d tag=%0d expected 1 1/5 1/7 0", dispatch_valid,
                     dispatch_data.src1_rdy, dispatch_data.src1_val, dispatch_data.src2_rdy,
                     dispatch_data.src2_val, dispatch_data.rob_tag);
        end
        dispatch_ready = 1'b1;
        tick();
    endtask

    task automatic test_wb_snoop();
        dispatch_ready = 1'b1;
        drive_op(2, 3, 5, 1'b1, 0); tick();
        drive_op(5, 3, 7, 1'b1, 1); tick();
        dispatch_ready = 1'b0;
        checks++;
        if (dispatch_data.src1_rdy !== 1'b0 || dispatch_data.src1_tag !== 4'd0) begin
            errors++;
            $display("FAIL snoop_pending: rdy=%0b tag=%0d expected 0/0", dispatch_data.src1_rdy, dispatch_data.src1_tag);
        end
        wb_valid = 1'b1; wb_tag = 4'd0; wb_data = 32'd42;
        tick();
        checks++;
        if (dispatch_data.src1_rdy !== 1'b1 || dispatch_data.src1_val !== 32'd42) begin
            errors++;
            $display("FAIL snoop_held: rdy=%0b val=%0d expected 1/42", dispatch_data.src1_rdy, dispatch_data.src1_val);
        end
        dispatch_ready = 1'b1;
        drive_op(2, 2, 6, 1'b1, 2); tick();
        drive_op(6, 2, 8, 1'b1, 3);
        wb_valid = 1'b1; wb_tag = 4'd2; wb_data = 32'd77;
        tick();
        checks++;
        if (dispatch_data.src1_rdy !== 1'b1 || dispatch_data.src1_val !== 32'd77) begin
            errors++;
            $display("FAIL snoop_bypass: rdy=%0b val=%0d expected 1/77", dispatch_data.src1_rdy, dispatch_data.src1_val);
        end
        tick();
    endtask

    task automatic test_backpressure();
        iiq_entry_t held;
        dispatch_ready = 1'b1;
        drive_op(2, 3, 9, 1'b1, 4); tick();
        held = sb[0];
        dispatch_ready = 1'b0;
        for (int c = 0; c < 3; c++) begin
            drive_op(2, 3, 10, 1'b1, 5);
            #1;
            checks++;
            if (decode_ready !== 1'b0 || rob_alloc_valid !== 1'b0) begin
                errors++;
                $display("FAIL bp_stall: cycle=%0d ready=%0b alloc=%0b expected 0/0", c, decode_ready, rob_alloc_valid);
            end
            tick();
            checks++;
            if (dispatch_data !== held) begin
                errors++;
                $display("FAIL bp_stable: cycle=%0d got=%h expected=%h", c, dispatch_data, held);
            end
        end
        dispatch_ready = 1'b1;
        tick();
    endtask

    task automatic test_retire_race();
        dispatch_ready = 1'b1;
        drive_op(2, 3, 5, 1'b1, 0); tick();
        drive_op(2, 3, 5, 1'b1, 3);
        retire_valid = 1'b1; retire_rd = 5'd5; retire_tag = 4'd0;
        tick();
        retire_valid = 1'b1; retire_rd = 5'd5; retire_tag = 4'd2;
        tick();
        drive_op(5, 2, 0, 1'b0, 4); tick();
        checks++;
        if (dispatch_data.src1_rdy !== 1'b0 || dispatch_data.src1_tag !== 4'd3) begin
            errors++;
            $display("FAIL retire_race: rdy=%0b tag=%0d expected 0/3", dispatch_data.src1_rdy, dispatch_data.src1_tag);
        end
        retire_valid = 1'b1; retire_rd = 5'd5; retire_tag = 4'd3;
        tick();
        drive_op(5, 2, 0, 1'b0, 5); tick();
        checks++;
        if (dispatch_data.src1_rdy !== 1'b1 || dispatch_data.src1_val !== arf[5]) begin
            errors++;
            $display("FAIL retire_clear: rdy=%0b val=%0d expected 1/%0d", dispatch_data.src1_rdy,
                     dispatch_data.src1_val, arf[5]);
        end
        tick();
    endtask

    task automatic test_flush();
        dispatch_ready = 1'b1;
        drive_op(2, 3, 5, 1'b1, 6); tick();
        dispatch_ready = 1'b0;
        flush = 1'b1;
        drive_op(2, 3, 11, 1'b1, 7);
        #1;
        checks++;
        if (decode_ready !== 1'b0 || rob_alloc_valid !== 1'b0) begin
            errors++;
            $display("FAIL flush_gate: ready=%0b alloc=%0b expected 0/0", decode_ready, rob_alloc_valid);
        end
        tick();
        checks++;
        if (dispatch_valid !== 1'b0) begin
            errors++;
            $display("FAIL flush_drop: dispatch_valid=%0b expected=0", dispatch_valid);
        end
        dispatch_ready = 1'b1;
        drive_op(5, 11, 0, 1'b0, 8); tick();
        checks++;
        if (dispatch_data.src1_rdy !== 1'b1 || dispatch_data.src1_val !== arf[5]) begin
            errors++;
            $display("FAIL flush_rat: rdy=%0b val=%0d expected 1/%0d", dispatch_data.src1_rdy,
                     dispatch_data.src1_val, arf[5]);
        end
        tick();
    endtask

    task automatic test_x0();
        dispatch_ready = 1'b1;
        drive_op(2, 3, 0, 1'b1, 7); tick();
        drive_op(0, 0, 4, 1'b1, 8); tick();
        checks++;
        if (dispatch_data.src1_rdy !== 1'b1 || dispatch_data.src1_val !== '0 ||
            dispatch_data.src2_rdy !== 1'b1 || dispatch_data.src2_val !== '0) begin
            errors++;
            $display("FAIL x0_read: s1=%0b/%h s2=%0b/%h expected 1/0 1/0", dispatch_data.src1_rdy,
                     dispatch_data.src1_val, dispatch_data.src2_rdy, dispatch_data.src2_val);
        end
        tick();
        rob_alloc_ready = 1'b0;
        drive_op(2, 3, 12, 1'b1, 9);
        #1;
        checks++;
        if (decode_ready !== 1'b0 || rob_alloc_valid !== 1'b0) begin
            errors++;
            $display("FAIL rob_full: ready=%0b alloc=%0b expected 0/0", decode_ready, rob_alloc_valid);
        end
        tick();
        rob_alloc_ready = 1'b1;
    endtask

    task automatic test_back_to_back();
        for (int i = 0; i < 24; i++) begin
            dispatch_ready = ($urandom_range(0, 3) != 0);
            drive_op(int'($urandom_range(0, 7)), int'($urandom_range(0, 7)), int'($urandom_range(0, 7)),
                     1'($urandom_range(0, 1)), i % 16);
            decode_valid = ($urandom_range(0, 4) != 0);
            if ($urandom_range(0, 1) == 1) begin
                wb_valid = 1'b1;
                wb_tag   = ROB_TAG_WIDTH'($urandom_range(0, 15));
                wb_data  = $urandom;
            end
            if ($urandom_range(0, 2) == 0) begin
                retire_valid = 1'b1;
                retire_rd    = AREG_W'($urandom_range(1, 7));
                retire_tag   = m_tag[retire_rd];
            end
            tick();
        end
        dispatch_ready = 1'b1;
        repeat (2) tick();
    endtask

    task automatic test_async_reset();
        dispatch_ready = 1'b0;
        drive_op(2, 3, 1, 1'b1, 10); tick();
        #2 rst_aL = 1'b0;
        #1;
        checks++;
        if (dispatch_valid !== 1'b0 || dispatch_data !== '0) begin
            errors++;
            $display("FAIL async_reset: valid=%0b data=%h expected 0/0", dispatch_valid, dispatch_data);
        end
        model_clear();
        @(negedge clk);
        rst_aL = 1'b1;
        dispatch_ready = 1'b1;
        drive_op(1, 2, 0, 1'b0, 11); tick();
        checks++;
        if (dispatch_data.src1_rdy !== 1'b1 || dispatch_data.src1_val !== arf[1]) begin
            errors++;
            $display("FAIL async_rat: rdy=%0b val=%0d expected 1/%0d", dispatch_data.src1_rdy,
                     dispatch_data.src1_val, arf[1]);
        end
        tick();
    endtask

    initial begin
        foreach (arf[i]) arf[i] = XLEN'(1000 + i);
        arf[0] = 32'hDEAD_BEEF;
        arf[2] = 32'd5;
        arf[3] = 32'd7;
        foreach (m_tag[i]) m_tag[i] = '0;
        decode_valid = 1'b0; decode_op = '0; decode_rs1 = '0; decode_rs2 = '0; decode_rd = '0;
        decode_rd_wr = 1'b0; decode_imm = '0; rob_alloc_ready = 1'b1; rob_tail_tag = '0;
        wb_valid = 1'b0; wb_tag = '0; wb_data = '0;
        retire_valid = 1'b0; retire_rd = '0; retire_tag = '0;
        flush = 1'b0; dispatch_ready = 1'b0;
        model_clear();
        test_reset();
        test_basic();
        test_wb_snoop();
        test_backpressure();
        test_retire_race();
        test_flush();
        test_x0();
        test_back_to_back();
        test_async_reset();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
